// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions used by the pipeline stages.
// Holds the word/mask types and the MEM-stage access sequencer state encoding.
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS1,
      ACCESS2,
      DONE
   } mem_access_state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-cache sequencer: issues loads/stores, runs the two-access LDI/STI, stalls the pipe.
// Define MEM_STALL_CNT_EN to build the 32-bit stall-cycle counter behind stall_count.
module mem_access_ctrl
   import lc3b_types::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              read,
   input  logic              write,
   input  logic              indirect_enable,
   input  logic [1:0]        mem_byte_enable,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pipe_load,
   input  logic              dmem_resp,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              dmem_read,
   output logic              dmem_write,
   output logic [ADDR_W-1:0] dmem_address,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic [1:0]        dmem_byte_enable,
   output logic [DATA_W-1:0] rdata,
   output logic              stall,
   output logic [31:0]       stall_count
);

   mem_access_state_t state, next_state;
   logic [ADDR_W-1:0] ptr;
   logic              req;
   logic              load;

   assign req  = read | write;
   // Write wins when the control word asserts both.
   assign load = read & ~write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state       = state;
      dmem_read        = 1'b0;
      dmem_write       = 1'b0;
      dmem_address     = '0;
      dmem_wdata       = '0;
      dmem_byte_enable = 2'b11;
      stall            = 1'b0;
      case (state)
         IDLE: begin
            stall = req;
            if (req) next_state = ACCESS1;
         end
         ACCESS1: begin
            stall        = 1'b1;
            dmem_address = address;
            if (indirect_enable) begin
               // Pointer fetch is always a full-word read.
               dmem_read = 1'b1;
            end else begin
               dmem_read        = load;
               dmem_write       = write;
               dmem_byte_enable = mem_byte_enable;
               dmem_wdata       = wdata;
            end
            if (dmem_resp) next_state = indirect_enable ? ACCESS2 : DONE;
         end
         ACCESS2: begin
            stall            = 1'b1;
            dmem_address     = ptr;
            dmem_read        = load;
            dmem_write       = write;
            dmem_byte_enable = mem_byte_enable;
            dmem_wdata       = wdata;
            if (dmem_resp) next_state = DONE;
         end
         DONE: begin
            // Wait here until the whole pipe advances so the access is not re-issued.
            if (pipe_load) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr   <= '0;
         rdata <= '0;
      end else if (dmem_resp) begin
         if (state == ACCESS1 && indirect_enable) begin
            ptr <= ADDR_W'(dmem_rdata);
         end else if ((state == ACCESS1 || state == ACCESS2) && load) begin
            rdata <= dmem_rdata;
         end
      end
   end

`ifdef MEM_STALL_CNT_EN
   logic [31:0] stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign stall_count = stall_cnt;
`else
   assign stall_count = '0;
`endif

   read_write_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(read && write));

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed LDR/STB/LDI/STI, DONE hold, stray response, reset.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic        indirect_enable = 1'b0;
   logic [1:0]  mem_byte_enable = 2'b11;
   logic [15:0] address = '0;
   logic [15:0] wdata = '0;
   logic        pipe_load = 1'b0;
   logic        dmem_resp = 1'b0;
   logic [15:0] dmem_rdata = '0;
   logic        dmem_read;
   logic        dmem_write;
   logic [15:0] dmem_address;
   logic [15:0] dmem_wdata;
   logic [1:0]  dmem_byte_enable;
   logic [15:0] rdata;
   logic        stall;
   logic [31:0] stall_count;

   mem_access_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .read             (read),
      .write            (write),
      .indirect_enable  (indirect_enable),
      .mem_byte_enable  (mem_byte_enable),
      .address          (address),
      .wdata            (wdata),
      .pipe_load        (pipe_load),
      .dmem_resp        (dmem_resp),
      .dmem_rdata       (dmem_rdata),
      .dmem_read        (dmem_read),
      .dmem_write       (dmem_write),
      .dmem_address     (dmem_address),
      .dmem_wdata       (dmem_wdata),
      .dmem_byte_enable (dmem_byte_enable),
      .rdata            (rdata),
      .stall            (stall),
      .stall_count      (stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [1:0]  be;
      logic [15:0] wd;
      int          len;
   } req_t;

   typedef struct {
      int          w;
      logic [15:0] d;
   } resp_t;

   typedef struct {
      int          slen;
      logic [15:0] rd;
   } done_t;

   req_t  req_q[$];
   resp_t resp_q[$];
   done_t done_q[$];

   int total = 0;
   int bad   = 0;
   int stray_req = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push_req(input bit wr, input logic [15:0] addr, input logic [1:0] be,
                           input logic [15:0] wd, input int len);
      req_t r;
      r.wr = wr; r.addr = addr; r.be = be; r.wd = wd; r.len = len;
      req_q.push_back(r);
   endtask

   task automatic push_resp(input int w, input logic [15:0] d);
      resp_t r;
      r.w = w; r.d = d;
      resp_q.push_back(r);
   endtask

   task automatic push_done(input int slen, input logic [15:0] rd);
      done_t r;
      r.slen = slen; r.rd = rd;
      done_q.push_back(r);
   endtask

   // Cache model: answers each request after its queued wait count.
   initial begin : responder
      bit    active = 1'b0;
      int    cnt = 0;
      int    stray_done = 0;
      resp_t cur;
      cur.w = 0; cur.d = '0;
      forever begin
         @(negedge clk);
         dmem_resp = 1'b0;
         if (!rst_n) begin
            active = 1'b0;
         end else if (stray_req != stray_done) begin
            stray_done = stray_req;
            dmem_resp  = 1'b1;
            dmem_rdata = 16'hDEAD;
         end else if (dmem_read || dmem_write) begin
            if (!active) begin
               if (resp_q.size() == 0) begin
                  check("resp_avail", 32'd0, 32'd1);
                  cur.w = 0; cur.d = '0;
               end else begin
                  cur = resp_q.pop_front();
               end
               active = 1'b1;
               cnt    = 0;
            end
            if (cnt == cur.w) begin
               dmem_resp  = 1'b1;
               dmem_rdata = cur.d;
               active     = 1'b0;
            end else begin
               cnt++;
            end
         end
      end
   end

   initial begin : monitor
      bit    in_req = 1'b0;
      int    len = 0;
      int    run = 0;
      req_t  cur;
      done_t d;
      cur.wr = 1'b0; cur.addr = '0; cur.be = 2'b11; cur.wd = '0; cur.len = 0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            in_req = 1'b0;
            run    = 0;
         end else begin
            if (dmem_read || dmem_write) begin
               if (!in_req) begin
                  if (req_q.size() == 0) begin
                     check("unexpected_req", 32'd1, 32'd0);
                     cur.wr = dmem_write; cur.addr = dmem_address;
                     cur.be = dmem_byte_enable; cur.wd = dmem_wdata; cur.len = 0;
                  end else begin
                     cur = req_q.pop_front();
                  end
                  in_req = 1'b1;
                  len    = 0;
               end
               len++;
               check("req_write", 32'(dmem_write), 32'(cur.wr));
               check("req_read", 32'(dmem_read), 32'(!cur.wr));
               check("req_addr", 32'(dmem_address), 32'(cur.addr));
               check("req_be", 32'(dmem_byte_enable), 32'(cur.be));
               if (cur.wr) check("req_wdata", 32'(dmem_wdata), 32'(cur.wd));
               if (dmem_resp) begin
                  in_req = 1'b0;
                  if (cur.len > 0) check("req_len", 32'(len), 32'(cur.len));
               end
            end else if (in_req) begin
               check("req_dropped", 32'd0, 32'd1);
               in_req = 1'b0;
            end
            if (stall) begin
               run++;
            end else if (run > 0) begin
               if (done_q.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  d = done_q.pop_front();
                  check("stall_len", 32'(run), 32'(d.slen));
                  check("done_rdata", 32'(rdata), 32'(d.rd));
               end
               run = 0;
            end
         end
      end
   end

   task automatic run_op(input bit rd, input bit wr, input bit ind, input logic [1:0] be,
                         input logic [15:0] addr, input logic [15:0] wd, input int hold);
      int n;
      @(posedge clk);
      #1;
      read = rd; write = wr; indirect_enable = ind;
      mem_byte_enable = be; address = addr; wdata = wd;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (stall && n < 40);
      if (stall) check("done_timeout", 32'd1, 32'd0);
      for (int i = 0; i < hold; i++) begin
         check("done_hold_req", 32'(dmem_read | dmem_write), 32'd0);
         check("done_hold_stall", 32'(stall), 32'd0);
         @(posedge clk);
         #1;
      end
      pipe_load = 1'b1;
      @(posedge clk);
      #1;
      pipe_load = 1'b0;
      read = 1'b0; write = 1'b0; indirect_enable = 1'b0;
   endtask

   initial begin : stimulus
      #12;
      check("rst_dmem_read", 32'(dmem_read), 32'd0);
      check("rst_dmem_write", 32'(dmem_write), 32'd0);
      check("rst_dmem_address", 32'(dmem_address), 32'd0);
      check("rst_dmem_wdata", 32'(dmem_wdata), 32'd0);
      check("rst_dmem_be", 32'(dmem_byte_enable), 32'd3);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_stall_count", stall_count, 32'd0);
      #10;
      rst_n = 1'b1;

      // LDR
      push_req(1'b0, 16'h3000, 2'b11, 16'h0000, 1);
      push_resp(0, 16'hBEEF);
      push_done(2, 16'hBEEF);
      run_op(1'b1, 1'b0, 1'b0, 2'b11, 16'h3000, 16'h0000, 0);

      // STB: response data must not reach rdata
      push_req(1'b1, 16'h3001, 2'b10, 16'hAB00, 4);
      push_resp(3, 16'h7777);
      push_done(5, 16'hBEEF);
      run_op(1'b0, 1'b1, 1'b0, 2'b10, 16'h3001, 16'hAB00, 0);

      // LDI, then held in DONE for 3 cycles
      push_req(1'b0, 16'h4000, 2'b11, 16'h0000, 1);
      push_req(1'b0, 16'h5000, 2'b11, 16'h0000, 2);
      push_resp(0, 16'h5000);
      push_resp(1, 16'h1234);
      push_done(4, 16'h1234);
      run_op(1'b1, 1'b0, 1'b1, 2'b11, 16'h4000, 16'h0000, 3);

      // STI
      push_req(1'b0, 16'h4000, 2'b11, 16'h0000, 2);
      push_req(1'b1, 16'h6002, 2'b11, 16'h00FF, 1);
      push_resp(1, 16'h6002);
      push_resp(0, 16'h9999);
      push_done(4, 16'h1234);
      run_op(1'b0, 1'b1, 1'b1, 2'b11, 16'h4000, 16'h00FF, 0);

      // Stray response while idle with no request
      @(posedge clk);
      #1;
      stray_req++;
      repeat (3) @(posedge clk);
      #1;
      check("stray_rdata", 32'(rdata), 32'h1234);
      check("stray_stall", 32'(stall), 32'd0);
      check("stray_no_req", 32'(dmem_read | dmem_write), 32'd0);
`ifdef MEM_STALL_CNT_EN
      check("stall_count_total", stall_count, 32'd15);
`else
      check("stall_count_off", stall_count, 32'd0);
`endif

      // LDI aborted by reset in ACCESS2
      push_req(1'b0, 16'h4000, 2'b11, 16'h0000, 1);
      push_resp(0, 16'h5000);
      @(posedge clk);
      #1;
      read = 1'b1; indirect_enable = 1'b1; mem_byte_enable = 2'b11; address = 16'h4000;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("acc2_read", 32'(dmem_read), 32'd1);
      check("acc2_addr", 32'(dmem_address), 32'h5000);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_dmem_read", 32'(dmem_read), 32'd0);
      check("abort_dmem_addr", 32'(dmem_address), 32'd0);
      check("abort_rdata", 32'(rdata), 32'd0);
      check("abort_idle_stall", 32'(stall), 32'd1);
      check("abort_stall_count", stall_count, 32'd0);
      read = 1'b0; indirect_enable = 1'b0;
      #1;
      check("abort_idle_noreq", 32'(stall), 32'd0);
      @(negedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_no_req", 32'(dmem_read | dmem_write), 32'd0);

      // LDR after reset
      push_req(1'b0, 16'h3002, 2'b11, 16'h0000, 3);
      push_resp(2, 16'h0A0B);
      push_done(4, 16'h0A0B);
      run_op(1'b1, 1'b0, 1'b0, 2'b11, 16'h3002, 16'h0000, 0);

      repeat (3) @(posedge clk);
      #1;
      check("req_q_left", 32'(req_q.size()), 32'd0);
      check("resp_q_left", 32'(resp_q.size()), 32'd0);
      check("done_q_left", 32'(done_q.size()), 32'd0);
      check("final_rdata", 32'(rdata), 32'h0A0B);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage memory sequencer for the pipelined LC-3b, directly downstream of the EX/MEM control-word register.
- Consumes that register's `read`, `write`, `indirect_enable` and `mem_byte_enable` together with the MEM-stage address and store data.
- Drives the data-cache request interface and holds the pipeline (`stall`) until the access completes.
- Sequences the two-access LDI/STI operations and returns load data to the MEM/WB boundary.

Parameters:
- ADDR_W, 16, address width (lc3b_word).
- DATA_W, 16, data width (lc3b_word).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- read  in  1  control-word mem_read for the instruction in MEM.
- write  in  1  control-word mem_write for the instruction in MEM.
- indirect_enable  in  1  LDI/STI: the first access fetches a pointer.
- mem_byte_enable  in  2  byte mask for the final access.
- address  in  16  effective address from MEM-stage MAR.
- wdata  in  16  store data from MEM-stage MDR.
- pipe_load  in  1  global pipeline-advance strobe; the MEM stage retires on the edge where it is 1.
- dmem_resp  in  1  cache completion, 1-cycle pulse.
- dmem_rdata  in  16  cache read data, valid with dmem_resp.
- dmem_read  out  1  cache read request.
- dmem_write  out  1  cache write request.
- dmem_address  out  16  cache address.
- dmem_wdata  out  16  cache write data.
- dmem_byte_enable  out  2  cache byte mask.
- rdata  out  16  registered load result to MEM/WB.
- stall  out  1  hold all upstream pipeline registers.
- stall_count  out  32  stall-cycle counter; only meaningful with MEM_STALL_CNT_EN.

Behaviour:
- Request: req = read | write. If both are 1, write wins; a simulation assertion fires.
- FSM states: IDLE, ACCESS1, ACCESS2, DONE. State register is async-reset to IDLE.
- Reset values: dmem_read = 0, dmem_write = 0, dmem_address = 0, dmem_wdata = 0, dmem_byte_enable = 2'b11, rdata = 0, stall = 0, pointer register = 0.
- IDLE:
  - Cache outputs inactive; stall = req (combinational).
  - req = 1 -> ACCESS1.
- ACCESS1:
  - dmem_address = address.
  - If indirect_enable: dmem_read = 1, byte_enable = 11.
  - Otherwise: dmem_read = read & ~write, dmem_write = write, byte_enable = mem_byte_enable, dmem_wdata = wdata.
  - stall = 1.
  - On dmem_resp with indirect_enable: ptr <= dmem_rdata, -> ACCESS2.
  - On dmem_resp otherwise: rdata <= dmem_rdata (reads only), -> DONE.
- ACCESS2:
  - dmem_address = ptr; read/write, wdata and byte_enable as in the non-indirect case; stall = 1.
  - On dmem_resp: rdata <= dmem_rdata for reads, -> DONE.
- DONE:
  - Cache outputs inactive; stall = 0.
  - pipe_load = 1 -> IDLE. pipe_load = 0 (another stage stalling) -> stay in DONE; no re-issue.
- Latency, non-indirect with dmem_resp in its first request cycle: stall asserted 2 cycles (IDLE, ACCESS1); DONE in cycle 3.
- Indirect access adds one cycle per extra cache response.
- Cache request hold: dmem_* must stay stable from request assertion until the dmem_resp cycle inclusive.
- Reset mid-access: dmem_read/write drop immediately (asynchronous); the in-flight transaction is abandoned.
- dmem_resp in IDLE or DONE is ignored.
- A control word with req = 0 never enters ACCESS1; rdata holds its previous value.

Optional Feature:
- MEM_STALL_CNT_EN defined:
  - 32-bit stall_count increments every cycle with stall = 1; async-reset to 0.
  - Wraps from 0xFFFFFFFF to 0.
- Not defined: stall_count tied to 0; no counter flops.

Decomposition:
- lc3b_types (existing) provides lc3b_word and lc3b_mem_wmask.
- Add to lc3b_types: a mem_access_state_t enum (IDLE, ACCESS1, ACCESS2, DONE).
- Single module; no sub-module needed. The pointer and rdata registers are inline always_ff blocks.

Test Plan:
- LDR: read = 1, address = 0x3000, dmem_resp one cycle after request with rdata = 0xBEEF -> dmem_read high exactly 1 cycle at 0x3000, stall 2 cycles, rdata = 0xBEEF.
- STB: write = 1, address = 0x3001, mem_byte_enable = 10, wdata = 0xAB00, resp after 3 wait cycles -> dmem_write held 4 cycles, byte_enable = 10, stall 5 cycles.
- LDI:
  - Stimulus: indirect = 1, read = 1, address = 0x4000; first response 0x5000, second response 0x1234.
  - Required: reads issued at 0x4000 then 0x5000, second with byte_enable = 11; rdata = 0x1234.
- STI: indirect = 1, write = 1, address = 0x4000, pointer = 0x6002, wdata = 0x00FF -> read at 0x4000, then write at 0x6002 with wdata 0x00FF.
- DONE with pipe_load = 0 for 3 cycles -> no new dmem request, state held; advances on pipe_load = 1.
- rst_n pulled low during LDI ACCESS2 -> dmem_read = 0 same cycle, state IDLE, rdata = 0; with MEM_STALL_CNT_EN, stall_count = 0.
